mips_multicycle_core: RTL

Multicycle MIPS core, the parametrised successor to the single-cycle top level. It shares one ALU and one unified instruction/data memory port across the cycles of each instruction, under a control FSM. The datapath width is parametrised. Memory has a req/ready handshake, so wait states are tolerated. The core adds `addi`, `j`, and a trap-on-illegal-opcode halt.

---
 rtl/mips_multicycle_core.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS core: one shared ALU and one unified instruction/data memory port, sequenced by a control FSM.
// Latency: R-type/sw/addi 4, lw 5, beq/j 3 cycles with zero-wait memory; each wait cycle adds 1 to FETCH/MEMRD/MEMWR.
// Backpressure: the FETCH/MEMRD/MEMWR states hold mem_req with a stable address/data until mem_ready is seen high.
//
// Ports:
//   clk, rst_n            - clock (rising edge) and asynchronous active-low reset
//   mem_req/mem_we        - memory request and write strobe (mem_we only meaningful with mem_req)
//   mem_addr/mem_wdata    - byte address and store data, both XLEN wide
//   mem_rdata/mem_ready   - read data (fetch uses [31:0]) and access-complete handshake
//   pc_o, halted, instret - current PC, trap indicator, retired-instruction count
// Optional feature macro: MIPS_MC_INSTRET_EN builds the retired-instruction counter; otherwise instret is tied to 0.
module mips_multicycle_core #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [XLEN-1:0] pc_o,
    output logic            halted,
    output logic [31:0]     instret
);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_TRAP
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     ir_q, ir_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] alu_q, alu_d;
    logic [XLEN-1:0] mdr_q, mdr_d;

    logic [XLEN-1:0] rf_q [32];
    logic            rf_we;
    logic [4:0]      rf_wa;
    logic [XLEN-1:0] rf_wd;
    logic            retire;

    // Instruction fields
    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      rs, rt, rd;
    logic [XLEN-1:0] sign_imm;
    logic [XLEN-1:0] rs_val, rt_val;
    logic            unused_shamt;

    assign opcode       = ir_q[31:26];
    assign rs           = ir_q[25:21];
    assign rt           = ir_q[20:16];
    assign rd           = ir_q[15:11];
    assign funct        = ir_q[5:0];
    assign unused_shamt = ^ir_q[10:6];
    assign sign_imm     = {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};

    // r0 is hard-wired to zero on the read side as well as discarded on write
    assign rs_val = (rs == 5'd0) ? '0 : rf_q[rs];
    assign rt_val = (rt == 5'd0) ? '0 : rf_q[rt];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        alu_d   = alu_q;
        mdr_d   = mdr_q;
        rf_we   = 1'b0;
        rf_wa   = '0;
        rf_wd   = '0;
        retire  = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = rs_val;
                b_d   = rt_val;
                // Branch target is computed speculatively here so BRANCH only has to compare
                alu_d = pc_q + (sign_imm << 2);
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_d   = a_q + sign_imm;
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_ready) begin
                    mdr_d   = mem_rdata;
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                rf_we   = 1'b1;
                rf_wa   = rt;
                rf_wd   = mdr_q;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                state_d = S_ALUWB;
                case (funct)
                    6'h20:   alu_d = a_q + b_q;
                    6'h22:   alu_d = a_q - b_q;
                    6'h24:   alu_d = a_q & b_q;
                    6'h25:   alu_d = a_q | b_q;
                    6'h2A:   alu_d = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                    default: state_d = S_TRAP;
                endcase
            end
            S_ALUWB: begin
                rf_we   = 1'b1;
                rf_wa   = rd;
                rf_wd   = alu_q;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                if (a_q == b_q) begin
                    pc_d = alu_q;
                end
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                alu_d   = a_q + sign_imm;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we   = 1'b1;
                rf_wa   = rt;
                rf_wd   = alu_q;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                // pc_q already points past the jump, so the region bits come from PC+4
                pc_d    = {pc_q[XLEN-1:28], ir_q[25:0], 2'b00};
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            alu_q   <= alu_d;
            mdr_q   <= mdr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we && (rf_wa != 5'd0)) begin
            rf_q[rf_wa] <= rf_wd;
        end
    end

    // Memory port is a pure decode of state and registers, so it drops the cycle reset asserts
    assign mem_req   = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign mem_we    = (state_q == S_MEMWR);
    assign mem_addr  = (state_q == S_FETCH) ? pc_q :
                       ((state_q == S_MEMRD) || (state_q == S_MEMWR)) ? alu_q : '0;
    assign mem_wdata = (state_q == S_MEMWR) ? b_q : '0;
    assign pc_o      = pc_q;
    assign halted    = (state_q == S_TRAP);

`ifdef MIPS_MC_INSTRET_EN
    logic [31:0] instret_q;

    // No retire ever fires in TRAP, which is what freezes the count there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
    assign instret       = '0;
`endif

endmodule
